// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM states, PPROT bit indices and width helpers for the APB RAM completer
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// rtl/apb_ram_mem.sv - word array with per-byte write enables, registered read port and async clear
module apb_ram_mem #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_W     = DATA_WIDTH / 8,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STRB_W-1:0]     wr_be,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Read data is zero whenever no read is being answered, so the bus sees 0 outside RESP.
    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_ram_slave.sv
// rtl/apb_ram_slave.sv - APB4 RAM completer with fixed wait states; APB_PROT_CHECK_EN enables unprivileged-write errors
module apb_ram_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    input  logic [2:0]                   PPROT,
    output logic                         PREADY,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PSLVERR
);

    localparam int STRB_W    = strb_width(DATA_WIDTH);
    localparam int LANE_W    = lane_bits(DATA_WIDTH);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int IDX_HI    = IDX_W + LANE_W - 1;
    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    apb_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic                  src_write;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [2:0]            src_prot;
    logic                  range_err, align_err, prot_err, acc_err;
    logic                  setup, rd_en, commit;
    logic [STRB_W-1:0]     wr_be;
    logic                  unused_prot;

    // In IDLE the decode looks at the live bus so a zero-wait transfer can answer on the next edge.
    always_comb begin
        src_write = pwrite_q;
        src_addr  = paddr_q;
        src_prot  = pprot_q;
        if (state_q == IDLE) begin
            src_write = PWRITE;
            src_addr  = PADDR;
            src_prot  = PPROT;
        end
    end

    always_comb begin
        range_err = |src_addr[ADDR_WIDTH-1:IDX_HI+1];
        align_err = |src_addr[LANE_W-1:0];
`ifdef APB_PROT_CHECK_EN
        prot_err  = src_write & ~src_prot[PROT_PRIV];
`else
        prot_err  = 1'b0;
`endif
        acc_err   = range_err | align_err | prot_err;
    end

    assign unused_prot = ^src_prot;
    assign setup       = PSEL & ~PENABLE;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        pprot_d    = pprot_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    pwrite_d = PWRITE;
                    paddr_d  = PADDR;
                    pwdata_d = PWDATA;
                    pstrb_d  = PSTRB;
                    pprot_d  = PPROT;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = 4'(WAIT_LOAD);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready_d  = (state_d == RESP);
        pslverr_d = (state_d == RESP) & acc_err;
        rd_en     = (state_d == RESP) & ~src_write & ~acc_err;
    end

    // Writes land on the completing edge only, so an abort or reset before then leaves the RAM untouched.
    always_comb begin
        commit = (state_q == RESP) & PSEL & PENABLE & pready_q & pwrite_q & ~acc_err;
        wr_be  = commit ? pstrb_q : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            pprot_q    <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            pprot_q    <= pprot_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    apb_ram_mem #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_W     (STRB_W),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_be   (wr_be),
        .wr_idx  (paddr_q[IDX_HI:LANE_W]),
        .wr_data (pwdata_q),
        .rd_en   (rd_en),
        .rd_idx  (src_addr[IDX_HI:LANE_W]),
        .rd_data (PRDATA)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// tb/tb_apb_ram_slave.sv - directed scoreboard bench for apb_ram_slave with zero and three wait states
module tb_apb_ram_slave;

`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel0, psel3, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [31:0] prdata0, prdata3;

    always #5 pclk = ~pclk;

    apb_ram_slave #(.WAIT_CYCLES(0)) dut0 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
    );

    apb_ram_slave #(.WAIT_CYCLES(3)) dut3 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3)
    );

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [256];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic wr, input logic [31:0] addr, input logic [2:0] prot);
        return (addr >= 32'h400) || (addr[1:0] != 2'b00) || (PROT_EN && wr && !prot[0]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = '0;
        exp_q.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that ends the RESP cycle.
    task automatic xfer(input bit use3, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input string tag);
        exp_t        e;
        logic [31:0] w;
        int          waits;
        bit          done;
        e.err   = model_err(wr, addr, prot);
        e.rd    = !wr;
        e.rdata = (!wr && !e.err) ? model[addr[9:2]] : 32'h0;
        if (wr && !e.err) begin
            w = model[addr[9:2]];
            for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
            model[addr[9:2]] = w;
        end
        exp_q.push_back(e);
        psel0 = !use3; psel3 = use3; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge pclk);
            if (use3 ? pready3 : pready0) begin
                done = 1'b1;
            end else begin
                waits++;
                @(posedge pclk); #1;
            end
        end
        e = exp_q.pop_front();
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_waits"}, waits, use3 ? 32'd3 : 32'd0);
            chk({tag, "_slverr"}, {31'd0, use3 ? pslverr3 : pslverr0}, {31'd0, e.err});
            if (e.rd) chk({tag, "_rdata"}, use3 ? prdata3 : prdata0, e.rdata);
            @(posedge pclk); #1;
            chk({tag, "_ready_one_cycle"}, {31'd0, use3 ? pready3 : pready0}, 32'd0);
        end
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    logic seen;

    initial begin
        presetn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        clear_model();
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_pready0", {31'd0, pready0}, 32'd0);
        chk("reset_pslverr0", {31'd0, pslverr0}, 32'd0);
        chk("reset_prdata0", prdata0, 32'd0);
        chk("reset_pready3", {31'd0, pready3}, 32'd0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b001, "rd_10_after_reset");
        xfer(0, 1, 32'h20, 32'hDEADBEEF, 4'b0101, 3'b001, "wr_20_strb0101");
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001, "rd_20_raw");
        chk("rd_20_literal", model[8], 32'h00AD00EF);
        xfer(0, 1, 32'h24, 32'h11223344, 4'hF, 3'b001, "wr_24_full");
        xfer(0, 1, 32'h24, 32'hFFFFFFFF, 4'h0, 3'b001, "wr_24_strb0");
        xfer(0, 0, 32'h24, 32'h0, 4'hF, 3'b001, "rd_24");

        xfer(1, 1, 32'h04, 32'hCAFEF00D, 4'hF, 3'b001, "w3_wr_04");
        xfer(1, 0, 32'h04, 32'h0, 4'hF, 3'b001, "w3_rd_04");

        xfer(0, 1, 32'h00, 32'h12345678, 4'hF, 3'b001, "wr_00");
        xfer(0, 1, 32'h400, 32'hA5A5A5A5, 4'hF, 3'b001, "wr_400_range");
        xfer(0, 0, 32'h00, 32'h0, 4'hF, 3'b001, "rd_00_unchanged");
        xfer(0, 0, 32'h02, 32'h0, 4'hF, 3'b001, "rd_02_misaligned");
        xfer(0, 1, 32'h21, 32'h99999999, 4'hF, 3'b001, "wr_21_misaligned");
        xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b001, "rd_20_unchanged");
        xfer(0, 1, 32'h3FC, 32'h0BADF00D, 4'hF, 3'b001, "wr_3fc_last");
        xfer(0, 0, 32'h3FC, 32'h0, 4'hF, 3'b001, "rd_3fc_last");

        xfer(0, 1, 32'h08, 32'hAAAAAAAA, 4'hF, 3'b001, "wr_08_priv");
        xfer(0, 1, 32'h08, 32'h00000055, 4'hF, 3'b000, "wr_08_unpriv");
        xfer(0, 0, 32'h08, 32'h0, 4'hF, 3'b000, "rd_08_unpriv");
        xfer(0, 1, 32'h08, 32'h00000055, 4'hF, 3'b001, "wr_08_priv2");
        xfer(0, 0, 32'h08, 32'h0, 4'hF, 3'b010, "rd_08_after");

        // PSEL dropped in the middle of the wait states: no response, no write.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h5A5A5A5A;
        pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge pclk);
            seen = seen | pready3;
        end
        chk("abort_no_ready", {31'd0, seen}, 32'd0);
        @(posedge pclk); #1;
        xfer(1, 0, 32'h30, 32'h0, 4'hF, 3'b001, "abort_rd_30");

        // Reset asserted while RESP is being presented.
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("rst_resp_ready", {31'd0, pready0}, 32'd1);
        chk("rst_resp_rdata", prdata0, model[8]);
        presetn = 1'b0;
        #1;
        chk("rst_resp_ready_async", {31'd0, pready0}, 32'd0);
        chk("rst_resp_rdata_async", prdata0, 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b001, "rd_20_after_reset");

        // Reset during the second wait cycle of a write to 0x0C.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h13572468;
        pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #2;
        presetn = 1'b0;
        #1;
        chk("rst_wait_ready", {31'd0, pready3}, 32'd0);
        chk("rst_wait_slverr", {31'd0, pslverr3}, 32'd0);
        psel3 = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1, 0, 32'h0C, 32'h0, 4'hF, 3'b001, "rd_0c_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
